// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline scheduler types, stage indices and helpers
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_EX_BUSY
    } pipe_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    localparam int NUM_STAGES = 5;
    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;

    function automatic stage_ctrl_t stage(input logic en, input logic flush);
        return '{en: en, flush: flush};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that holds at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush scheduler for the five-stage pipeline
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_use,
    input  logic                 branch_taken,
    input  logic                 muldiv_start,
    input  logic                 muldiv_done,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_flush,
    output logic                 dmem_err,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    pipe_state_t                  state;
    pipe_state_t                  state_nxt;
    logic                         ex_pending;
    logic                         ex_pending_nxt;
    logic [TMO_W-1:0]             tmo_cnt;
    stage_ctrl_t [NUM_STAGES-1:0] ctrl;
    logic                         busy;
    logic                         mem_hold;
    logic                         ex_hold;
    logic                         unused_pc_flush;

    always_comb begin
        // a mul/div parked behind a memory freeze keeps EX occupied after release
        busy           = (state == ST_EX_BUSY) || ((state == ST_MEM_WAIT) && ex_pending);
        mem_hold       = (state == ST_MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
        ex_hold        = (busy || muldiv_start) && !muldiv_done;
        state_nxt      = ST_RUN;
        ex_pending_nxt = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            ctrl[i] = stage(1'b1, 1'b0);
        end

        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                ctrl[i] = stage(1'b0, 1'b1);
            end
        end else if (mem_hold) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                ctrl[i] = stage(1'b0, 1'b0);
            end
            ctrl[STG_MEM_WB] = stage(1'b1, 1'b1);
            state_nxt        = ST_MEM_WAIT;
            ex_pending_nxt   = busy || muldiv_start;
        end else if (ex_hold) begin
            ctrl[STG_PC]     = stage(1'b0, 1'b0);
            ctrl[STG_IF_ID]  = stage(1'b0, 1'b0);
            ctrl[STG_ID_EX]  = stage(1'b0, 1'b0);
            ctrl[STG_EX_MEM] = stage(1'b1, 1'b1);
            state_nxt        = ST_EX_BUSY;
        end else if (branch_taken) begin
            ctrl[STG_IF_ID] = stage(1'b1, 1'b1);
            ctrl[STG_ID_EX] = stage(1'b1, 1'b1);
        end else if (load_use) begin
            ctrl[STG_PC]    = stage(1'b0, 1'b0);
            ctrl[STG_IF_ID] = stage(1'b0, 1'b0);
            ctrl[STG_ID_EX] = stage(1'b1, 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            ex_pending <= 1'b0;
        end else begin
            state      <= state_nxt;
            ex_pending <= ex_pending_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt  <= '0;
            dmem_err <= 1'b0;
        end else if ((state == ST_MEM_WAIT) && !dmem_ready) begin
            if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_cnt >= TMO_LAST) begin
                dmem_err <= 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (!ctrl[STG_PC].en),
        .count(stall_cnt)
    );

    assign pc_en           = ctrl[STG_PC].en;
    assign if_id_en        = ctrl[STG_IF_ID].en;
    assign id_ex_en        = ctrl[STG_ID_EX].en;
    assign ex_mem_en       = ctrl[STG_EX_MEM].en;
    assign mem_wb_en       = ctrl[STG_MEM_WB].en;
    assign if_id_flush     = ctrl[STG_IF_ID].flush;
    assign id_ex_flush     = ctrl[STG_ID_EX].flush;
    assign ex_mem_flush    = ctrl[STG_EX_MEM].flush;
    assign mem_wb_flush    = ctrl[STG_MEM_WB].flush;
    assign unused_pc_flush = ctrl[STG_PC].flush;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int TMO     = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_FRZ  = 5'b00001;
    localparam logic [4:0] EN_EX   = 5'b00011;
    localparam logic [4:0] EN_LU   = 5'b00111;
    localparam logic [3:0] FL_ALL  = 4'b1111;
    localparam logic [3:0] FL_NONE = 4'b0000;
    localparam logic [3:0] FL_FRZ  = 4'b0001;
    localparam logic [3:0] FL_EX   = 4'b0010;
    localparam logic [3:0] FL_BR   = 4'b1100;
    localparam logic [3:0] FL_LU   = 4'b0100;

    localparam logic [6:0] I_0  = 7'b0000000;
    localparam logic [6:0] I_R  = 7'b1000000;
    localparam logic [6:0] I_LU = 7'b0100000;
    localparam logic [6:0] I_BR = 7'b0010000;
    localparam logic [6:0] I_ST = 7'b0001000;
    localparam logic [6:0] I_DN = 7'b0000100;
    localparam logic [6:0] I_RQ = 7'b0000010;
    localparam logic [6:0] I_RD = 7'b0000001;

    logic          clk = 1'b0;
    logic          rst, load_use, branch_taken, muldiv_start, muldiv_done, dmem_req, dmem_ready;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic          dmem_err;
    logic [CW-1:0] stall_cnt;
    logic [4:0]    en_act;
    logic [3:0]    fl_act;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(
        .MEM_TIMEOUT(TMO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_use    (load_use),
        .branch_taken(branch_taken),
        .muldiv_start(muldiv_start),
        .muldiv_done (muldiv_done),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush),
        .dmem_err    (dmem_err),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    assign en_act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl_act = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    typedef struct {
        logic [6:0] in;
        logic [4:0] en;
        logic [3:0] fl;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [6:0] in, input logic [4:0] en,
                                input logic [3:0] fl, input int cnt);
        vec_t v;
        v.in  = in;
        v.en  = en;
        v.fl  = fl;
        v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] in);
        rst          = in[6];
        load_use     = in[5];
        branch_taken = in[4];
        muldiv_start = in[3];
        muldiv_done  = in[2];
        dmem_req     = in[1];
        dmem_ready   = in[0];
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic [6:0] in,
                        input logic [4:0] en, input logic [3:0] fl);
        drive(in);
        @(negedge clk);
        check({name, " en"}, 32'(en_act), 32'(en));
        check({name, " flush"}, 32'(fl_act), 32'(fl));
        advance();
    endtask

    // reference state: is MEM frozen, is a mul/div outstanding, how long has MEM waited
    bit m_wait, m_op, m_err;
    int m_wlen, m_cnt;

    task automatic model_cycle(input logic [6:0] in);
        logic [4:0] e;
        logic [3:0] f;
        bit hold, op;
        hold = m_wait ? !in[0] : (in[1] && !in[0]);
        op   = m_op || in[3];
        if (in[6]) begin
            e = EN_NONE; f = FL_ALL;
        end else if (hold) begin
            e = EN_FRZ; f = FL_FRZ;
        end else if (op && !in[2]) begin
            e = EN_EX; f = FL_EX;
        end else if (in[4]) begin
            e = EN_ALL; f = FL_BR;
        end else if (in[5]) begin
            e = EN_LU; f = FL_LU;
        end else begin
            e = EN_ALL; f = FL_NONE;
        end
        check("rnd en", 32'(en_act), 32'(e));
        check("rnd flush", 32'(fl_act), 32'(f));
        check("rnd dmem_err", 32'(dmem_err), 32'(m_err));
        check("rnd stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (in[6]) begin
            m_wait = 0; m_op = 0; m_err = 0; m_wlen = 0; m_cnt = 0;
        end else begin
            if (m_wait && !in[0]) begin
                m_wlen++;
                if (m_wlen >= TMO) m_err = 1;
            end else begin
                m_wlen = 0;
            end
            if (!e[4]) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
            m_op   = hold ? op : (op && !in[2]);
            m_wait = hold;
        end
    endtask

    initial begin
        logic [6:0] rin;

        tbl.push_back(mk(I_R,                 EN_NONE, FL_ALL,  0));
        tbl.push_back(mk(I_R,                 EN_NONE, FL_ALL,  0));
        tbl.push_back(mk(I_0,                 EN_ALL,  FL_NONE, 0));
        tbl.push_back(mk(I_LU,                EN_LU,   FL_LU,   0));
        tbl.push_back(mk(I_0,                 EN_ALL,  FL_NONE, 1));
        tbl.push_back(mk(I_BR | I_LU,         EN_ALL,  FL_BR,   1));
        tbl.push_back(mk(I_RQ | I_RD,         EN_ALL,  FL_NONE, 1));
        tbl.push_back(mk(I_RQ | I_RD | I_LU,  EN_LU,   FL_LU,   1));
        tbl.push_back(mk(I_ST | I_DN,         EN_ALL,  FL_NONE, 2));
        tbl.push_back(mk(I_ST | I_DN | I_BR,  EN_ALL,  FL_BR,   2));
        tbl.push_back(mk(I_RQ | I_BR,         EN_FRZ,  FL_FRZ,  2));
        tbl.push_back(mk(I_RD | I_BR,         EN_ALL,  FL_BR,   3));
        tbl.push_back(mk(I_ST,                EN_EX,   FL_EX,   3));
        tbl.push_back(mk(I_RQ,                EN_FRZ,  FL_FRZ,  4));
        tbl.push_back(mk(I_RD,                EN_EX,   FL_EX,   5));
        tbl.push_back(mk(I_DN,                EN_ALL,  FL_NONE, 6));
        tbl.push_back(mk(I_R | I_LU,          EN_NONE, FL_ALL,  6));

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            @(negedge clk);
            check($sformatf("tbl[%0d] en", i), 32'(en_act), 32'(tbl[i].en));
            check($sformatf("tbl[%0d] flush", i), 32'(fl_act), 32'(tbl[i].fl));
            check($sformatf("tbl[%0d] stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
            advance();
        end
        check("post-reset stall_cnt", 32'(stall_cnt), 32'd0);
        check("post-reset dmem_err", 32'(dmem_err), 32'd0);

        // multi-cycle mul/div, done four cycles after start
        step("md rst", I_R, EN_NONE, FL_ALL);
        step("md start", I_ST, EN_EX, FL_EX);
        for (int i = 0; i < 3; i++) step("md busy", I_0, EN_EX, FL_EX);
        step("md done", I_DN, EN_ALL, FL_NONE);
        check("md stall_cnt", 32'(stall_cnt), 32'd4);
        step("md after", I_0, EN_ALL, FL_NONE);

        // memory wait with a taken branch held in frozen EX
        step("mw rst", I_R, EN_NONE, FL_ALL);
        for (int i = 0; i < 3; i++) step("mw frozen", I_RQ | I_BR, EN_FRZ, FL_FRZ);
        step("mw ready", I_RQ | I_RD | I_BR, EN_ALL, FL_BR);
        check("mw stall_cnt", 32'(stall_cnt), 32'd3);
        check("mw dmem_err", 32'(dmem_err), 32'd0);
        step("mw after", I_0, EN_ALL, FL_NONE);

        // memory never ready: timeout is sticky, stall counter saturates
        step("to rst", I_R, EN_NONE, FL_ALL);
        for (int i = 0; i < 20; i++) begin
            drive(I_RQ);
            @(negedge clk);
            check($sformatf("to[%0d] en", i), 32'(en_act), 32'(EN_FRZ));
            check($sformatf("to[%0d] dmem_err", i), 32'(dmem_err), 32'(i >= TMO + 1));
            check($sformatf("to[%0d] stall_cnt", i), 32'(stall_cnt),
                  32'((i > CNT_MAX) ? CNT_MAX : i));
            advance();
        end
        step("to rst mid-stall", I_R, EN_NONE, FL_ALL);
        check("to err cleared", 32'(dmem_err), 32'd0);
        check("to cnt cleared", 32'(stall_cnt), 32'd0);
        step("to run", I_0, EN_ALL, FL_NONE);

        // randomized traffic against the reference model
        step("rnd rst", I_R, EN_NONE, FL_ALL);
        m_wait = 0; m_op = 0; m_err = 0; m_wlen = 0; m_cnt = 0;
        for (int n = 0; n < 2000; n++) begin
            rin[6] = ($urandom_range(0, 59) == 0);
            rin[5] = ($urandom_range(0, 3) == 0);
            rin[4] = ($urandom_range(0, 4) == 0);
            rin[3] = ($urandom_range(0, 7) == 0);
            rin[2] = ($urandom_range(0, 2) == 0);
            rin[1] = ($urandom_range(0, 3) == 0);
            rin[0] = ($urandom_range(0, 2) == 0);
            drive(rin);
            @(negedge clk);
            model_cycle(rin);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
